fetch_stage: RTL and testbench

Fetch stage of the five-stage pipeline: owns the program counter, drives the instruction-memory address, and registers the F/D pipeline latch. It directly consumes the execute-stage redirect, `branch_ctrl` plus `jump_address`. On a redirect it reloads the PC, squashes the two younger in-flight instructions, and counts fetch and flush events for debug.

---
 rtl/fetch_stage.sv | 106 ++++++++++
 tb/tb_fetch_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, drives the instruction-memory address and the F/D latch,
// takes execute-stage redirects, and keeps saturating fetch/flush counters for debug.
module fetch_stage #(
   parameter int IMEM_AW = 12,
   parameter int CNT_W   = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               stall,
   input  logic               branch_ctrl,
   input  logic [31:0]        jump_address,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_data,
   output logic [31:0]        pc_fd,
   output logic [31:0]        pc_plus1_fd,
   output logic [31:0]        insn_fd,
   output logic               valid_fd,
   output logic               flush_dx,
   output logic [CNT_W-1:0]   fetch_cnt,
   output logic [CNT_W-1:0]   flush_cnt
);

   typedef enum logic {
      S_BOOT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               w_advance;
   logic               w_redirect;
   logic [31:0]        r_pc;
   logic [31:0]        r_pc_fd;
   logic [31:0]        r_insn_fd;
   logic               r_valid_fd;
   logic [CNT_W-1:0]   r_fetch_cnt;
   logic [CNT_W-1:0]   r_flush_cnt;

   // NOTE: every output of this block gets a default first, so no path leaves a
   // signal unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_redirect  = branch_ctrl;
      w_advance   = 1'b0;
      case (r_state)
         S_BOOT: begin
            if (branch_ctrl) begin
               w_state_nxt = S_RUN;
            end else if (!stall) begin
               w_advance   = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (!branch_ctrl && !stall) begin
               w_advance = 1'b1;
            end
         end
         default: w_state_nxt = S_BOOT;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values (e.g. r_pc_fd takes the old r_pc, not the incremented one).
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_BOOT;
         r_pc        <= 32'd0;
         r_pc_fd     <= 32'd0;
         r_insn_fd   <= 32'd0;
         r_valid_fd  <= 1'b0;
         r_fetch_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_redirect) begin
            // pc_fd is deliberately left alone; only the instruction becomes a nop
            r_pc       <= jump_address;
            r_insn_fd  <= 32'd0;
            r_valid_fd <= 1'b0;
            if (!(&r_flush_cnt)) begin
               r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
         end else if (w_advance) begin
            r_pc       <= r_pc + 32'd1;
            r_pc_fd    <= r_pc;
            r_insn_fd  <= imem_data;
            r_valid_fd <= 1'b1;
            if (!(&r_fetch_cnt)) begin
               r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
            end
         end
      end
   end

   // D/X must bubble at the same edge F/D is squashed, hence combinational
   assign flush_dx    = branch_ctrl & ~reset;
   assign imem_addr   = r_pc[IMEM_AW-1:0];
   assign pc_fd       = r_pc_fd;
   assign pc_plus1_fd = r_pc_fd + 32'd1;
   assign insn_fd     = r_insn_fd;
   assign valid_fd    = r_valid_fd;
   assign fetch_cnt   = r_fetch_cnt;
   assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, then randomized traffic against a
// behavioural model, with a CNT_W=4 copy exercising counter saturation.
module tb_fetch_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic        stall;
   logic        branch_ctrl;
   logic [31:0] jump_address;

   logic [11:0] imem_addr,   imem_addr4;
   logic [31:0] imem_data,   imem_data4;
   logic [31:0] pc_fd,       pc_fd4;
   logic [31:0] pc_plus1_fd, pc_plus1_fd4;
   logic [31:0] insn_fd,     insn_fd4;
   logic        valid_fd,    valid_fd4;
   logic        flush_dx,    flush_dx4;
   logic [15:0] fetch_cnt,   flush_cnt;
   logic [3:0]  fetch_cnt4,  flush_cnt4;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [11:0] a);
      return 32'h100 + {20'd0, a};
   endfunction

   assign imem_data  = mem_word(imem_addr);
   assign imem_data4 = mem_word(imem_addr4);

   fetch_stage #(.IMEM_AW(12), .CNT_W(16)) dut (
      .clock(clock), .reset(reset), .stall(stall), .branch_ctrl(branch_ctrl),
      .jump_address(jump_address), .imem_addr(imem_addr), .imem_data(imem_data),
      .pc_fd(pc_fd), .pc_plus1_fd(pc_plus1_fd), .insn_fd(insn_fd), .valid_fd(valid_fd),
      .flush_dx(flush_dx), .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
   );

   fetch_stage #(.IMEM_AW(12), .CNT_W(4)) dut4 (
      .clock(clock), .reset(reset), .stall(stall), .branch_ctrl(branch_ctrl),
      .jump_address(jump_address), .imem_addr(imem_addr4), .imem_data(imem_data4),
      .pc_fd(pc_fd4), .pc_plus1_fd(pc_plus1_fd4), .insn_fd(insn_fd4), .valid_fd(valid_fd4),
      .flush_dx(flush_dx4), .fetch_cnt(fetch_cnt4), .flush_cnt(flush_cnt4)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        r, s, b;
      logic [31:0] j;
      logic        e_fdx;
      logic [11:0] e_addr;
      logic [31:0] e_pcfd;
      logic [31:0] e_insn;
      logic        e_v;
      int          e_fc;
      int          e_flc;
   } vec_t;

   function automatic vec_t mk(input logic r, s, b, input logic [31:0] j, input logic fdx,
                               input logic [11:0] addr, input logic [31:0] pcfd, insn,
                               input logic v, input int fc, flc);
      vec_t t;
      t.r = r; t.s = s; t.b = b; t.j = j; t.e_fdx = fdx; t.e_addr = addr;
      t.e_pcfd = pcfd; t.e_insn = insn; t.e_v = v; t.e_fc = fc; t.e_flc = flc;
      return t;
   endfunction

   // behavioural model state
   logic [31:0] m_pc, m_pcfd, m_insn;
   logic        m_v;
   int          m_fc, m_flc;

   function automatic logic [31:0] sat(input int c, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (c > mx) ? mx : c;
   endfunction

   task automatic model_cycle(input logic r, s, b, input logic [31:0] j);
      reset = r; stall = s; branch_ctrl = b; jump_address = j;
      #1;
      check("flush_dx", {31'd0, flush_dx}, {31'd0, b & ~r});
      check("flush_dx4", {31'd0, flush_dx4}, {31'd0, b & ~r});
      if (r) begin
         m_pc = 0; m_pcfd = 0; m_insn = 0; m_v = 0; m_fc = 0; m_flc = 0;
      end else if (b) begin
         m_pc = j; m_insn = 0; m_v = 0; m_flc++;
      end else if (!s) begin
         m_pcfd = m_pc; m_insn = mem_word(m_pc[11:0]); m_v = 1'b1;
         m_pc = m_pc + 1; m_fc++;
      end
      @(posedge clock);
      #1;
      check("imem_addr", {20'd0, imem_addr}, {20'd0, m_pc[11:0]});
      check("pc_fd", pc_fd, m_pcfd);
      check("pc_plus1_fd", pc_plus1_fd, m_pcfd + 32'd1);
      check("insn_fd", insn_fd, m_insn);
      check("valid_fd", {31'd0, valid_fd}, {31'd0, m_v});
      check("fetch_cnt", {16'd0, fetch_cnt}, sat(m_fc, 16));
      check("flush_cnt", {16'd0, flush_cnt}, sat(m_flc, 16));
      check("pc_fd4", pc_fd4, m_pcfd);
      check("insn_fd4", insn_fd4, m_insn);
      check("fetch_cnt4", {28'd0, fetch_cnt4}, sat(m_fc, 4));
      check("flush_cnt4", {28'd0, flush_cnt4}, sat(m_flc, 4));
   endtask

   initial begin
      vec_t tbl[$];
      reset = 1'b1; stall = 1'b0; branch_ctrl = 1'b0; jump_address = 32'd0;

      // r s b  jump          fdx addr   pc_fd         insn      v fc flc
      tbl.push_back(mk(1, 0, 0, 32'h0,        0, 12'h0,   32'h0,        32'h0,    0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 32'h0,        0, 12'h1,   32'h0,        32'h100,  1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 32'h0,        0, 12'h2,   32'h1,        32'h101,  1, 2, 0));
      tbl.push_back(mk(0, 0, 0, 32'h0,        0, 12'h3,   32'h2,        32'h102,  1, 3, 0));
      tbl.push_back(mk(0, 0, 0, 32'h0,        0, 12'h4,   32'h3,        32'h103,  1, 4, 0));
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(0, 1, 0, 32'h0,     0, 12'h4,   32'h3,        32'h103,  1, 4, 0));
      tbl.push_back(mk(0, 0, 0, 32'h0,        0, 12'h5,   32'h4,        32'h104,  1, 5, 0));
      tbl.push_back(mk(0, 1, 1, 32'h40,       1, 12'h40,  32'h4,        32'h0,    0, 5, 1));
      tbl.push_back(mk(0, 0, 0, 32'h0,        0, 12'h41,  32'h40,       32'h140,  1, 6, 1));
      tbl.push_back(mk(0, 0, 1, 32'h10,       1, 12'h10,  32'h40,       32'h0,    0, 6, 2));
      tbl.push_back(mk(0, 0, 1, 32'h20,       1, 12'h20,  32'h40,       32'h0,    0, 6, 3));
      tbl.push_back(mk(0, 0, 0, 32'h0,        0, 12'h21,  32'h20,       32'h120,  1, 7, 3));
      tbl.push_back(mk(1, 0, 1, 32'h77,       0, 12'h0,   32'h0,        32'h0,    0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 12'h0,   32'h0,        32'h0,    0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 32'h0,        0, 12'h1,   32'h0,        32'h100,  1, 1, 0));
      tbl.push_back(mk(0, 0, 1, 32'hFFFFFFFF, 1, 12'hFFF, 32'h0,        32'h0,    0, 1, 1));
      tbl.push_back(mk(0, 0, 0, 32'h0,        0, 12'h0,   32'hFFFFFFFF, 32'h10FF, 1, 2, 1));
      tbl.push_back(mk(0, 0, 0, 32'h0,        0, 12'h1,   32'h0,        32'h100,  1, 3, 1));

      foreach (tbl[i]) begin
         reset = tbl[i].r; stall = tbl[i].s; branch_ctrl = tbl[i].b; jump_address = tbl[i].j;
         #1;
         check($sformatf("v%0d flush_dx", i), {31'd0, flush_dx}, {31'd0, tbl[i].e_fdx});
         @(posedge clock);
         #1;
         check($sformatf("v%0d imem_addr", i), {20'd0, imem_addr}, {20'd0, tbl[i].e_addr});
         check($sformatf("v%0d pc_fd", i), pc_fd, tbl[i].e_pcfd);
         check($sformatf("v%0d pc_plus1_fd", i), pc_plus1_fd, tbl[i].e_pcfd + 32'd1);
         check($sformatf("v%0d insn_fd", i), insn_fd, tbl[i].e_insn);
         check($sformatf("v%0d valid_fd", i), {31'd0, valid_fd}, {31'd0, tbl[i].e_v});
         check($sformatf("v%0d fetch_cnt", i), {16'd0, fetch_cnt}, tbl[i].e_fc);
         check($sformatf("v%0d flush_cnt", i), {16'd0, flush_cnt}, tbl[i].e_flc);
      end

      // randomized traffic against the model, starting from a reset
      model_cycle(1'b1, 1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 400; i++) begin
         logic        r, s, b;
         logic [31:0] j;
         r = ($urandom_range(0, 39) == 0);
         s = ($urandom_range(0, 3) == 0);
         b = ($urandom_range(0, 5) == 0);
         j = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFF - $urandom_range(0, 2)) : $urandom;
         model_cycle(r, s, b, j);
      end

      // saturation of the narrow counters, plus the wide ones still counting
      model_cycle(1'b1, 1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 20; i++) model_cycle(1'b0, 1'b0, 1'b0, 32'd0);
      check("sat fetch_cnt4", {28'd0, fetch_cnt4}, 32'd15);
      check("sat fetch_cnt", {16'd0, fetch_cnt}, 32'd20);
      for (int i = 0; i < 20; i++) model_cycle(1'b0, 1'b0, 1'b1, 32'h200 + i);
      check("sat flush_cnt4", {28'd0, flush_cnt4}, 32'd15);
      check("sat flush_cnt", {16'd0, flush_cnt}, 32'd20);
      check("sat fetch_cnt4 hold", {28'd0, fetch_cnt4}, 32'd15);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
